// File: rtl/picomips_fsm_core.sv
// picomips_fsm_core: multi-cycle picoMIPS core (PC, 8x N-bit register file,
// fixed-point ALU, decoder). Program ROM is external and read combinationally.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   sw8      handshake switch (async to clk, synchronised inside)
//   sws      switch data (async to clk, synchronised inside)
//   instr    instruction word at pc_addr
//   pc_addr  program counter
//   display  output register, written only by OUT
//   wait_sw  high while waiting on the sw8 press/release handshake
//   halted   high once HALT has executed
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | execute one instruction per clock
// S_WAIT_HI| LDSW issued, waiting for synchronised sw8 to go high
// S_WAIT_LO| switch pressed, waiting for release; release loads rd
// S_HALT   | terminal, everything frozen until reset

module picomips_fsm_core #(
  parameter  int N     = 8,
  parameter  int PSIZE = 4,
  localparam int ISIZE = N + 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw8,
  input  logic [N-1:0]     sws,
  input  logic [ISIZE-1:0] instr,
  output logic [PSIZE-1:0] pc_addr,
  output logic [N-1:0]     display,
  output logic             wait_sw,
  output logic             halted
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_HI, S_WAIT_LO, S_HALT} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_MULI = 3'b011;
  localparam logic [2:0] OP_LDSW = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic signed [2*N-1:0] SAT_MAX = (2*N)'(2**(N-1) - 1);
  localparam logic signed [2*N-1:0] SAT_MIN = (2*N)'(-(2**(N-1)));

  state_t           state_q;
  logic [PSIZE-1:0] pc_q;
  logic [N-1:0]     regs_q [8];
  logic [N-1:0]     display_q;
  logic             wait_sw_q;
  logic             halted_q;
  logic             sw8_meta_q, sw8_s_q;
  logic [N-1:0]     sws_meta_q, sws_s_q;

  logic [2:0]       op, rd, rs;
  logic [N-1:0]     imm;
  logic [N-1:0]     rd_val, rs_val;
  logic signed [2*N-1:0] prod, prod_sh;
  logic [N-1:0]     mul_res;

  assign op  = instr[ISIZE-1:ISIZE-3];
  assign rd  = instr[ISIZE-4:ISIZE-6];
  assign rs  = instr[ISIZE-7:ISIZE-9];
  assign imm = instr[N-1:0];

  // R0 is hard-wired to zero on the read side; writes to it are dropped below.
  assign rd_val = (rd == 3'd0) ? '0 : regs_q[rd];
  assign rs_val = (rs == 3'd0) ? '0 : regs_q[rs];

  // Q1.(N-1) multiply: full signed product, rescale, then saturate.
  always_comb begin
    prod    = $signed(rd_val) * $signed(imm);
    prod_sh = prod >>> (N - 1);
    mul_res = prod_sh[N-1:0];
    if (prod_sh > SAT_MAX)      mul_res = SAT_MAX[N-1:0];
    else if (prod_sh < SAT_MIN) mul_res = SAT_MIN[N-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      pc_q       <= '0;
      display_q  <= '0;
      wait_sw_q  <= 1'b0;
      halted_q   <= 1'b0;
      sw8_meta_q <= 1'b0;
      sw8_s_q    <= 1'b0;
      sws_meta_q <= '0;
      sws_s_q    <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      sw8_meta_q <= sw8;
      sw8_s_q    <= sw8_meta_q;
      sws_meta_q <= sws;
      sws_s_q    <= sws_meta_q;

      case (state_q)
        S_RUN: begin
          case (op)
            OP_NOP: pc_q <= pc_q + 1'b1;
            OP_ADD: begin
              if (rd != 3'd0) regs_q[rd] <= rd_val + rs_val;
              pc_q <= pc_q + 1'b1;
            end
            OP_ADDI: begin
              if (rd != 3'd0) regs_q[rd] <= rd_val + imm;
              pc_q <= pc_q + 1'b1;
            end
            OP_MULI: begin
              if (rd != 3'd0) regs_q[rd] <= mul_res;
              pc_q <= pc_q + 1'b1;
            end
            OP_LDSW: begin
              state_q   <= S_WAIT_HI;
              wait_sw_q <= 1'b1;
            end
            OP_JMP: pc_q <= imm[PSIZE-1:0];
            OP_OUT: begin
              display_q <= rd_val;
              pc_q      <= pc_q + 1'b1;
            end
            OP_HALT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: pc_q <= pc_q + 1'b1;
          endcase
        end
        S_WAIT_HI: begin
          if (sw8_s_q) state_q <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          // The release edge completes the load, using data sampled now.
          if (!sw8_s_q) begin
            if (rd != 3'd0) regs_q[rd] <= sws_s_q;
            pc_q      <= pc_q + 1'b1;
            state_q   <= S_RUN;
            wait_sw_q <= 1'b0;
          end
        end
        S_HALT: ;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign pc_addr = pc_q;
  assign display = display_q;
  assign wait_sw = wait_sw_q;
  assign halted  = halted_q;

endmodule
